alu_mc: RTL and testbench



---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_muldiv_seq.sv | 83 ++++++++
 rtl/alu_mc.sv | 160 ++++++++++++++++
 tb/tb_alu_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode, FSM-state and mode encodings for the
//                multi-cycle MIPS ALU (alu_mc) and its mul/div engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control encoding, compatible with the single-cycle ALU except SRL
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;

    // Handshake FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Mul/div engine mode select
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    // True for the opcodes that run on the iterative engine
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Iterative unsigned multiply (shift-add) and restoring divide,
//                one bit per clock, W iterations per operation.
//                MUL: {hi,lo} = a*b.  DIV: lo = a/b, hi = a%b (b != 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    localparam int c_CW = $clog2(W) + 1;

    logic [c_CW-1:0] r_cnt;
    logic            r_mode;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_lo;
    logic [W-1:0]    r_hi;

    // Multiply step: conditionally add multiplicand to the high half
    logic [W:0]      w_sum;
    // Divide step: shift next dividend bit into the partial remainder
    logic [W:0]      w_trial;
    logic            w_ge;
    logic [W-1:0]    w_diff;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_trial = {r_hi, r_lo[W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_b});
    // Remainder stays below the divisor, so the difference fits in W bits
    assign w_diff  = w_trial[W-1:0] - r_b;

    // Load operands on start, then run one iteration per clock until the count expires
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mode <= MD_MUL;
            r_b    <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
        end else if (start) begin
            r_cnt  <= c_CW'(W);
            r_mode <= mode;
            r_b    <= b;
            r_lo   <= a;
            r_hi   <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_mode == MD_MUL) begin
                r_hi <= w_sum[W:1];
                r_lo <= {w_sum[0], r_lo[W-1:1]};
            end else if (w_ge) begin
                r_hi <= w_diff;
                r_lo <= {r_lo[W-2:0], 1'b1};
            end else begin
                r_hi <= w_trial[W-1:0];
                r_lo <= {r_lo[W-2:0], 1'b0};
            end
        end
    end

    assign busy = (r_cnt != '0);
    // High during the final iteration; lo/hi hold the answer from the next edge on
    assign done = (r_cnt == c_CW'(1));
    assign lo   = r_lo;
    assign hi   = r_hi;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle MIPS ALU with valid/ready handshakes, single-cycle
//                logic/arith/shift ops, iterative unsigned MUL/DIV with a
//                HI/LO-style result pair, and zero/error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_con,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         zero,
    output logic         err
);

    logic [1:0]   r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [W-1:0] r_result;
    logic [W-1:0] r_result_hi;
    logic         r_zero;
    logic         r_err;
    logic         r_sel_eng;   // result comes from the mul/div engine

    logic         w_accept;
    logic         w_op_md;
    logic [W-1:0] w_res;
    logic [W-1:0] w_hi;
    logic         w_err;

    logic         w_eng_busy;
    logic         w_eng_done;
    logic [W-1:0] w_eng_lo;
    logic [W-1:0] w_eng_hi;

    assign w_accept = in_valid && r_in_ready;
    // Divide by zero bypasses the engine and completes in one cycle
    assign w_op_md  = is_muldiv(alu_con) && !((alu_con == OP_DIV) && (data_b == '0));

    // Single-cycle results, including the divide-by-zero and invalid-opcode outcomes
    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_err = 1'b0;
        case (alu_con)
            OP_AND: w_res = data_a & data_b;
            OP_OR:  w_res = data_a | data_b;
            OP_ADD: w_res = data_a + data_b;
            OP_NOR: w_res = ~(data_a | data_b);
            OP_SUB: w_res = data_a - data_b;
            OP_SLT: w_res = {{(W-1){1'b0}}, (data_a < data_b)};
            OP_SLL: w_res = data_a << data_b[SHW-1:0];
            OP_SRL: w_res = data_a >> data_b[SHW-1:0];
            OP_MUL: w_res = '0;
            OP_DIV: begin
                w_res = '1;
                w_hi  = data_a;
                w_err = 1'b1;
            end
            default: w_err = 1'b1;
        endcase
    end

    alu_muldiv_seq #(
        .W (W)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (w_accept && w_op_md),
        .mode  ((alu_con == OP_DIV) ? MD_DIV : MD_MUL),
        .a     (data_a),
        .b     (data_b),
        .busy  (w_eng_busy),
        .done  (w_eng_done),
        .lo    (w_eng_lo),
        .hi    (w_eng_hi)
    );

    // Handshake FSM with registered ready/valid and single-cycle result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b1;
            r_err       <= 1'b0;
            r_sel_eng   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_op_md) begin
                            r_state   <= ST_BUSY;
                            r_sel_eng <= 1'b1;
                            r_err     <= 1'b0;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_sel_eng   <= 1'b0;
                            r_result    <= w_res;
                            r_result_hi <= w_hi;
                            r_zero      <= (w_res == '0);
                            r_err       <= w_err;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_eng_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else if (!w_eng_busy) begin
                        // Engine idle without finishing: recover to a clean IDLE
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_sel_eng  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    // Engine registers hold their final value once iteration stops
    assign result    = r_sel_eng ? w_eng_lo : r_result;
    assign result_hi = r_sel_eng ? w_eng_hi : r_result_hi;
    assign zero      = r_sel_eng ? (w_eng_lo == '0) : r_zero;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Scoreboard bench for alu_mc at W=32 and W=8. Stimulus pushes
//                hand-computed expectations; per-instance monitors pop and
//                compare whenever out_valid is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        iv32, ir32, ov32, or32, z32, e32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, r32, h32;

    logic        iv8, ir8, ov8, or8, z8, e8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, r8, h8;

    alu_mc #(.W(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .alu_con(op32), .data_a(a32), .data_b(b32), .out_valid(ov32),
        .out_ready(or32), .result(r32), .result_hi(h32), .zero(z32), .err(e32)
    );

    alu_mc #(.W(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .alu_con(op8), .data_a(a8), .data_b(b8), .out_valid(ov8),
        .out_ready(or8), .result(r8), .result_hi(h8), .zero(z8), .err(e8)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs32  = 0;
    int hs8   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the W=32 instance
    exp_t c32;
    bit   act32 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            act32 = 1'b0;
        end else if (ov32) begin
            if (!act32) begin
                if (q32.size() == 0) begin
                    total++; bad++;
                    $display("FAIL m32 unexpected out_valid: got result=%0h want no output", r32);
                end else begin
                    c32   = q32.pop_front();
                    act32 = 1'b1;
                    chk("m32 latency", 32'(cyc - c32.acc), 32'(c32.lat));
                end
            end
            if (act32) begin
                chk("m32 result", r32, c32.res);
                chk("m32 result_hi", h32, c32.hi);
                chk("m32 zero", {31'b0, z32}, {31'b0, c32.z});
                chk("m32 err", {31'b0, e32}, {31'b0, c32.e});
                chk("m32 in_ready in DONE", {31'b0, ir32}, 32'd0);
                if (or32) begin
                    act32 = 1'b0;
                    hs32++;
                end
            end
        end
    end

    // Monitor for the W=8 instance
    exp_t c8;
    bit   act8 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            act8 = 1'b0;
        end else if (ov8) begin
            if (!act8) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL m8 unexpected out_valid: got result=%0h want no output", r8);
                end else begin
                    c8   = q8.pop_front();
                    act8 = 1'b1;
                    chk("m8 latency", 32'(cyc - c8.acc), 32'(c8.lat));
                end
            end
            if (act8) begin
                chk("m8 result", {24'b0, r8}, c8.res);
                chk("m8 result_hi", {24'b0, h8}, c8.hi);
                chk("m8 zero", {31'b0, z8}, {31'b0, c8.z});
                chk("m8 err", {31'b0, e8}, {31'b0, c8.e});
                chk("m8 in_ready in DONE", {31'b0, ir8}, 32'd0);
                if (or8) begin
                    act8 = 1'b0;
                    hs8++;
                end
            end
        end
    end

    function automatic logic rdy(input bit s8);
        return s8 ? ir8 : ir32;
    endfunction

    function automatic logic vld(input bit s8);
        return s8 ? ov8 : ov32;
    endfunction

    function automatic int hsc(input bit s8);
        return s8 ? hs8 : hs32;
    endfunction

    // Issue one operation, push its expectation, and wait for its handshake.
    // hold>0 stalls out_ready for that many cycles after out_valid rises.
    task automatic issue(input bit s8, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [31:0] eh,
                         input bit ez, input bit ee, input int lat, input int hold);
        exp_t e;
        int   n;
        int   hs0;
        @(posedge clk); #1;
        hs0 = hsc(s8);
        if (s8) begin
            op8 = op; a8 = a[7:0]; b8 = b[7:0]; iv8 = 1'b1; or8 = (hold == 0);
        end else begin
            op32 = op; a32 = a; b32 = b; iv32 = 1'b1; or32 = (hold == 0);
        end
        n = 0;
        while (!rdy(s8) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept timeout: got in_ready=0 want 1");
        end
        e.res = er; e.hi = eh; e.z = ez; e.e = ee; e.lat = lat; e.acc = cyc;
        if (s8) q8.push_back(e); else q32.push_back(e);
        @(posedge clk); #1;
        if (s8) iv8 = 1'b0; else iv32 = 1'b0;
        if (hold > 0) begin
            n = 0;
            while (!vld(s8) && n < 100) begin
                @(posedge clk); #1; n++;
            end
            for (int k = 0; k < hold; k++) begin
                chk("stall in_ready", {31'b0, rdy(s8)}, 32'd0);
                if (k == 1) begin
                    if (s8) begin op8 = 4'b0010; a8 = 8'd1; b8 = 8'd1; iv8 = 1'b1; end
                    else begin op32 = 4'b0010; a32 = 32'd1; b32 = 32'd1; iv32 = 1'b1; end
                end
                if (k == 3) begin
                    if (s8) iv8 = 1'b0; else iv32 = 1'b0;
                end
                @(posedge clk); #1;
            end
            if (s8) begin iv8 = 1'b0; or8 = 1'b1; end
            else begin iv32 = 1'b0; or32 = 1'b1; end
        end
        n = 0;
        while (hsc(s8) == hs0 && n < 200) begin
            chk("in_ready low while busy", {31'b0, rdy(s8)}, 32'd0);
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL handshake timeout: got no handshake want one");
        end
        chk("in_ready after handshake", {31'b0, rdy(s8)}, 32'd1);
        chk("out_valid after handshake", {31'b0, vld(s8)}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; or32 = 1'b1;
        iv8  = 1'b0; op8  = '0; a8  = '0; b8  = '0; or8  = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst in_ready", {31'b0, ir32}, 32'd1);
        chk("rst out_valid", {31'b0, ov32}, 32'd0);
        chk("rst result", r32, 32'd0);
        chk("rst result_hi", h32, 32'd0);
        chk("rst zero", {31'b0, z32}, 32'd1);
        chk("rst err", {31'b0, e32}, 32'd0);
        chk("rst8 in_ready", {31'b0, ir8}, 32'd1);
        chk("rst8 zero", {31'b0, z8}, 32'd1);

        // W=32 directed vectors
        issue(0, 4'b0010, 32'd5, 32'd7, 32'd12, 32'd0, 0, 0, 1, 0);
        issue(0, 4'b0011, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 0, 0, 33, 0);
        issue(0, 4'b0101, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33, 0);
        issue(0, 4'b0101, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 0, 1, 1, 0);
        issue(0, 4'b0110, 32'd3, 32'd3, 32'd0, 32'd0, 1, 0, 1, 0);
        issue(0, 4'b0111, 32'd1, 32'd2, 32'd1, 32'd0, 0, 0, 1, 0);
        issue(0, 4'b0111, 32'd2, 32'd1, 32'd0, 32'd0, 1, 0, 1, 0);
        issue(0, 4'b1000, 32'd1, 32'd33, 32'd2, 32'd0, 0, 0, 1, 0);
        issue(0, 4'b1001, 32'h8000_0000, 32'd31, 32'd1, 32'd0, 0, 0, 1, 0);
        issue(0, 4'b0000, 32'hC, 32'hA, 32'h8, 32'd0, 0, 0, 1, 0);
        issue(0, 4'b0100, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 0, 0, 1, 0);
        issue(0, 4'b0011, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1, 0, 33, 0);

        // Back-pressure with an ignored in_valid pulse during DONE
        issue(0, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 32'd0, 0, 0, 1, 5);

        // Reset 10 cycles into a MUL abandons it
        @(posedge clk); #1;
        op32 = 4'b0011; a32 = 32'd3; b32 = 32'd5; iv32 = 1'b1; or32 = 1'b1;
        chk("mul-abort accept ready", {31'b0, ir32}, 32'd1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort out_valid", {31'b0, ov32}, 32'd0);
        chk("abort in_ready", {31'b0, ir32}, 32'd1);
        chk("abort result", r32, 32'd0);
        chk("abort zero", {31'b0, z32}, 32'd1);
        chk("abort err", {31'b0, e32}, 32'd0);
        repeat (40) @(posedge clk);

        // Invalid opcode
        issue(0, 4'b1111, 32'd9, 32'd9, 32'd0, 32'd0, 1, 1, 1, 0);
        issue(0, 4'b1010, 32'd1, 32'd1, 32'd0, 32'd0, 1, 1, 1, 0);

        // W=8 instance
        issue(1, 4'b0010, 32'd5, 32'd7, 32'd12, 32'd0, 0, 0, 1, 0);
        issue(1, 4'b0011, 32'hFF, 32'd2, 32'hFE, 32'd1, 0, 0, 9, 0);
        issue(1, 4'b0101, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 9, 0);
        issue(1, 4'b0101, 32'd100, 32'd0, 32'hFF, 32'd100, 0, 1, 1, 0);
        issue(1, 4'b1000, 32'd1, 32'd9, 32'd2, 32'd0, 0, 0, 1, 0);

        repeat (5) @(posedge clk);
        if (q32.size() != 0 || q8.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover expectations: got %0d want 0", q32.size() + q8.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
